// File: rtl/comp_8_if.sv
// ============================================================================
// Module      : comp_8_if
// Description : Operand/result bundle for the 8-bit magnitude comparator.
//               The master drives A and B and observes Result; the slave
//               (the comparator) samples A and B and drives Result.
// Signals     : A      [7:0]  operand A
//               B      [7:0]  operand B
//               Result [7:0]  registered relation flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface comp_8_if;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Result;

  modport master (
    output A,
    output B,
    input  Result
  );

  modport slave (
    input  A,
    input  B,
    output Result
  );
endinterface : comp_8_if

`default_nettype wire

// File: rtl/comp_8.sv
// ============================================================================
// Module      : comp_8
// Description : 8-bit magnitude comparator with a registered relation-flag
//               vector. Every flag is derived from the same A/B sample and
//               appears on Result one clock after it was captured.
//                 Result[0] GT_U   A >  B unsigned
//                 Result[1] LT_U   A <  B unsigned
//                 Result[2] EQ     A == B
//                 Result[3] GT_S   A >  B signed  (COMP8_SIGNED_EN, else 0)
//                 Result[4] LT_S   A <  B signed  (COMP8_SIGNED_EN, else 0)
//                 Result[5] GE_U   A >= B unsigned
//                 Result[6] LE_U   A <= B unsigned
//                 Result[7] NE     A != B
// Ports       : Clk    - system clock, rising edge active
//               Reset  - asynchronous, active-high reset (Result -> 8'h00)
//               bus    - comp_8_if.slave (A, B in; Result out)
// Macro       : COMP8_SIGNED_EN - builds the signed GT/LT flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// 4-bit MSB-first comparator slice: each lower bit only matters when every
// bit above it is equal.
module comp_8_slice (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  output logic            gt,
  output logic            lt,
  output logic            eq
);
  logic [3:0] bit_eq;

  assign bit_eq = ~(a ^ b);

  assign gt = (a[3] & ~b[3])
            | (bit_eq[3] & a[2] & ~b[2])
            | (bit_eq[3] & bit_eq[2] & a[1] & ~b[1])
            | (bit_eq[3] & bit_eq[2] & bit_eq[1] & a[0] & ~b[0]);

  assign lt = (~a[3] & b[3])
            | (bit_eq[3] & ~a[2] & b[2])
            | (bit_eq[3] & bit_eq[2] & ~a[1] & b[1])
            | (bit_eq[3] & bit_eq[2] & bit_eq[1] & ~a[0] & b[0]);

  assign eq = &bit_eq;
endmodule : comp_8_slice

module comp_8 (
  input  wire logic Clk,
  input  wire logic Reset,
  comp_8_if.slave   bus
);
  localparam int NUM_SLICES = 2;

  // Index 0 is the low nibble, index 1 the high nibble.
  logic [NUM_SLICES-1:0] slice_gt;
  logic [NUM_SLICES-1:0] slice_lt;
  logic [NUM_SLICES-1:0] slice_eq;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      comp_8_slice u_slice (
        .a  (bus.A[gi*4 +: 4]),
        .b  (bus.B[gi*4 +: 4]),
        .gt (slice_gt[gi]),
        .lt (slice_lt[gi]),
        .eq (slice_eq[gi])
      );
    end
  endgenerate

  // Upper slice decides unless its nibbles are equal.
  logic gt_u;
  logic lt_u;
  logic eq_all;

  assign gt_u   = slice_gt[1] | (slice_eq[1] & slice_gt[0]);
  assign lt_u   = slice_lt[1] | (slice_eq[1] & slice_lt[0]);
  assign eq_all = slice_eq[1] & slice_eq[0];

  logic gt_s;
  logic lt_s;

`ifdef COMP8_SIGNED_EN
  // Differing sign bits: the negative operand (MSB set) is the smaller one.
  // Matching sign bits: two's-complement order equals unsigned order.
  logic sign_diff;
  assign sign_diff = bus.A[7] ^ bus.B[7];
  assign gt_s      = sign_diff ? bus.B[7] : gt_u;
  assign lt_s      = sign_diff ? bus.A[7] : lt_u;
`else
  assign gt_s = 1'b0;
  assign lt_s = 1'b0;
`endif

  logic [7:0] flags;
  assign flags = { ~eq_all,          // [7] NE
                   lt_u | eq_all,    // [6] LE_U
                   gt_u | eq_all,    // [5] GE_U
                   lt_s,             // [4] LT_S
                   gt_s,             // [3] GT_S
                   eq_all,           // [2] EQ
                   lt_u,             // [1] LT_U
                   gt_u };           // [0] GT_U

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.Result <= 8'h00;
    end else begin
      bus.Result <= flags;
    end
  end
endmodule : comp_8

`default_nettype wire

// File: tb/tb_comp_8.sv
// ============================================================================
// Module      : tb_comp_8
// Description : Self-checking bench for comp_8. Expected flags come from a
//               behavioural model using plain relational operators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp_8;
  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  comp_8_if bus ();

  comp_8 u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r    = 8'h00;
    r[0] = (a > b);
    r[1] = (a < b);
    r[2] = (a == b);
`ifdef COMP8_SIGNED_EN
    r[3] = ($signed(a) > $signed(b));
    r[4] = ($signed(a) < $signed(b));
`endif
    r[5] = (a >= b);
    r[6] = (a <= b);
    r[7] = (a != b);
    return r;
  endfunction

  // Drive a pair between edges, then look at Result just after the edge.
  task automatic apply_and_check(input logic [7:0] a, input logic [7:0] b,
                                 input string name);
    logic [7:0] exp;
    @(negedge Clk);
    bus.A = a;
    bus.B = b;
    exp   = model(a, b);
    @(posedge Clk);
    #1;
    checks++;
    if (bus.Result !== exp) begin
      errors++;
      $display("FAIL %s A=%h B=%h: got %h expected %h", name, a, b, bus.Result, exp);
    end
  endtask

  task automatic test_reset;
    // Reset held from time zero: Result must be clear.
    #1;
    checks++;
    if (bus.Result !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: got %h expected 00", bus.Result);
    end
    @(negedge Clk);
    Reset = 1'b0;
    apply_and_check(8'h05, 8'h03, "pre_reset");
    // Assert between edges: clears without a clock edge.
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Result !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got %h expected 00", bus.Result);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (bus.Result !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 00", bus.Result);
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.Result !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_no_edge: got %h expected 00", bus.Result);
    end
    @(posedge Clk);
    #1;
    checks++;
`ifdef COMP8_SIGNED_EN
    if (bus.Result !== 8'hA9) begin
      errors++;
      $display("FAIL reset_first_edge: got %h expected a9", bus.Result);
    end
`else
    if (bus.Result !== 8'hA1) begin
      errors++;
      $display("FAIL reset_first_edge: got %h expected a1", bus.Result);
    end
`endif
  endtask

  task automatic test_boundaries;
    apply_and_check(8'h7F, 8'h7F, "equal_7f");
    apply_and_check(8'h80, 8'h01, "sign_boundary");
    apply_and_check(8'h00, 8'hFF, "opposite_boundary");
    apply_and_check(8'h80, 8'h7F, "min_vs_max_signed");
    apply_and_check(8'hFF, 8'hFF, "equal_ff");
    apply_and_check(8'h00, 8'h00, "equal_00");
  endtask

  task automatic test_latency;
    apply_and_check(8'h05, 8'h03, "latency_gt");
    apply_and_check(8'h03, 8'h05, "latency_lt");
    apply_and_check(8'h10, 8'h10, "latency_eq");
    // Glitch between edges must not reach Result until the next edge.
    @(negedge Clk);
    bus.A = 8'hFF;
    bus.B = 8'h00;
    #1;
    checks++;
    if (bus.Result !== 8'h64) begin
      errors++;
      $display("FAIL latency_hold: got %h expected 64", bus.Result);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    for (int i = 0; i < 65536; i++) begin
      a = i[15:8];
      b = i[7:0];
      apply_and_check(a, b, "sweep");
      r = bus.Result;
      checks++;
      if ((r[0] + r[1] + r[2]) != 1 || r === 8'h00) begin
        errors++;
        $display("FAIL sweep_onehot_u A=%h B=%h: got %h expected one of GT/LT/EQ", a, b, r);
      end
`ifdef COMP8_SIGNED_EN
      checks++;
      if ((r[3] + r[4] + r[2]) != 1) begin
        errors++;
        $display("FAIL sweep_onehot_s A=%h B=%h: got %h expected one of GTS/LTS/EQ", a, b, r);
      end
`endif
    end
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = (($urandom % 4) == 0) ? a : 8'($urandom);
      apply_and_check(a, b, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    bus.A  = 8'h05;
    bus.B  = 8'h03;
    test_reset();
    test_boundaries();
    test_latency();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule : tb_comp_8

`default_nettype wire
